// File: rtl/symbol_timing_ctrl_pkg.sv
// Shared timing-recovery defaults (common with the polyphase filters) and the
// small types used by the interpolation controller.
`ifndef STC_CNT_W
`define STC_CNT_W(n) ($clog2((n) + 1))
`endif

package symbol_timing_ctrl_pkg;

  localparam int NB_MU_DEF = 22;
  localparam int NB_PH_DEF = 4;
  localparam int SPS_DEF   = 2;

  localparam longint MU_ONE       = 64'sd1 <<< NB_MU_DEF;
  localparam longint MAX_STEP_DEF = MU_ONE >>> 2;
  localparam longint MIN_STEP_DEF = -MAX_STEP_DEF;

  typedef enum logic [1:0] {
    WRAP_NONE = 2'd0,
    WRAP_UP   = 2'd1,
    WRAP_DOWN = 2'd2
  } wrap_e;

  typedef struct packed {
    logic skip;
    logic stuff;
  } slip_t;

endpackage

// File: rtl/symbol_timing_ctrl_lock.sv
// Lock detector: run-length counters on good/bad loop corrections drive a
// hysteretic lock flag.
module timing_lock_detector #(
  parameter int NB_ERR     = 27,
  parameter int LOCK_THR   = 4096,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_err_valid,
  input  logic signed [NB_ERR-1:0] i_err,
  input  logic                     i_clr,
  output logic                     o_lock
);

  localparam int EW = NB_ERR + 1;
  localparam int GW = `STC_CNT_W(LOCK_CNT);
  localparam int BW = `STC_CNT_W(UNLOCK_CNT);

  logic signed [EW-1:0] err_x;
  logic        [EW-1:0] mag;
  logic                 good;
  logic        [GW-1:0] good_cnt;
  logic        [BW-1:0] bad_cnt;

  // One extra bit so the most-negative correction has a representable magnitude.
  assign err_x = EW'(i_err);
  assign mag   = err_x[EW-1] ? unsigned'(-err_x) : unsigned'(err_x);
  assign good  = (mag < EW'(LOCK_THR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      o_lock   <= 1'b0;
    end else if (i_clr) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      o_lock   <= 1'b0;
    end else if (i_err_valid) begin
      if (good) begin
        bad_cnt <= '0;
        if (good_cnt != GW'(LOCK_CNT)) good_cnt <= good_cnt + 1'b1;
        if (good_cnt >= GW'(LOCK_CNT - 1)) o_lock <= 1'b1;
      end else begin
        good_cnt <= '0;
        if (bad_cnt != BW'(UNLOCK_CNT)) bad_cnt <= bad_cnt + 1'b1;
        if (bad_cnt >= BW'(UNLOCK_CNT - 1)) o_lock <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/symbol_timing_ctrl.sv
// Interpolation/timing controller: integrates loop-filter corrections into mu,
// turns mu wraps into skip/stuff requests for the symbol strobe, tracks lock.
module symbol_timing_ctrl
  import symbol_timing_ctrl_pkg::*;
#(
  parameter int NB_ERR     = 27,
  parameter int NB_MU      = NB_MU_DEF,
  parameter int NB_PH      = NB_PH_DEF,
  parameter int SPS        = SPS_DEF,
  parameter int MAX_STEP   = 2 ** (NB_MU - 2),
  parameter int LOCK_THR   = 2 ** 12,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_sample_en,
  input  logic                     i_err_valid,
  input  logic signed [NB_ERR-1:0] i_err,
  input  logic                     i_freeze,
  input  logic                     i_load,
  input  logic        [NB_MU-1:0]  i_mu_init,
  output logic                     o_strobe,
  output logic        [NB_PH-1:0]  o_phase_idx,
  output logic        [NB_MU-1:0]  o_mu,
  output logic                     o_skip,
  output logic                     o_stuff,
  output logic                     o_ovf,
  output logic                     o_lock
);

  localparam int CW    = ((NB_ERR > NB_MU + 2) ? NB_ERR : NB_MU + 2) + 1;
  localparam int SW    = NB_MU + 2;
  localparam int CNT_W = $clog2(SPS);

  localparam logic signed [CW-1:0] STEP_HI = CW'(MAX_STEP);
  localparam logic signed [CW-1:0] STEP_LO = -STEP_HI;

  logic [NB_MU-1:0]     mu;
  logic signed [CW-1:0] err_x;
  logic signed [SW-1:0] step_s;
  logic signed [SW-1:0] sum;
  logic                 int_en;
  wrap_e                wrap;

  slip_t                pend, pend_n;
  logic                 ovf_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 cnt_last;
  logic                 strobe_n;

  assign int_en = i_err_valid && !i_load && !i_freeze;
  assign err_x  = CW'(i_err);

  always_comb begin
    if (err_x > STEP_HI)      step_s = SW'(STEP_HI);
    else if (err_x < STEP_LO) step_s = SW'(STEP_LO);
    else                      step_s = SW'(err_x);
  end

  // Two guard bits: bit NB_MU flags an up-wrap, the sign bit a down-wrap.
  assign sum = $signed({2'b00, mu}) + step_s;

  always_comb begin
    wrap = WRAP_NONE;
    if (int_en) begin
      if (sum[SW-1])      wrap = WRAP_DOWN;
      else if (sum[SW-2]) wrap = WRAP_UP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mu      <= '0;
      o_skip  <= 1'b0;
      o_stuff <= 1'b0;
    end else begin
      if (i_load)      mu <= i_mu_init;
      else if (int_en) mu <= sum[NB_MU-1:0];
      o_skip  <= (wrap == WRAP_UP);
      o_stuff <= (wrap == WRAP_DOWN);
    end
  end

  assign o_mu        = mu;
  assign o_phase_idx = mu[NB_MU-1 -: NB_PH];

  assign cnt_last = (cnt == CNT_W'(SPS - 1));

  // The strobe decision consumes the flags as they stood before this cycle's
  // wrap, so a wrap coinciding with a sample is serviced on the next sample.
  always_comb begin
    pend_n   = pend;
    ovf_n    = o_ovf;
    cnt_n    = cnt;
    strobe_n = 1'b0;
    if (i_sample_en) begin
      if (pend.skip) begin
        strobe_n    = 1'b1;
        cnt_n       = '0;
        pend_n.skip = 1'b0;
      end else if (cnt_last && pend.stuff) begin
        pend_n.stuff = 1'b0;
      end else if (cnt_last) begin
        strobe_n = 1'b1;
        cnt_n    = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
    unique case (wrap)
      WRAP_UP: begin
        if (pend_n.skip)       ovf_n        = 1'b1;
        else if (pend_n.stuff) pend_n.stuff = 1'b0;
        else                   pend_n.skip  = 1'b1;
      end
      WRAP_DOWN: begin
        if (pend_n.stuff)     ovf_n        = 1'b1;
        else if (pend_n.skip) pend_n.skip  = 1'b0;
        else                  pend_n.stuff = 1'b1;
      end
      default: ;
    endcase
    if (i_load) begin
      pend_n = '0;
      ovf_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      o_ovf    <= 1'b0;
      cnt      <= '0;
      o_strobe <= 1'b0;
    end else begin
      pend     <= pend_n;
      o_ovf    <= ovf_n;
      cnt      <= cnt_n;
      o_strobe <= strobe_n;
    end
  end

  timing_lock_detector #(
    .NB_ERR     (NB_ERR),
    .LOCK_THR   (LOCK_THR),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_lock (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_err_valid (i_err_valid),
    .i_err       (i_err),
    .i_clr       (i_load),
    .o_lock      (o_lock)
  );

endmodule

// File: doc/symbol_timing_ctrl.md
Name: symbol_timing_ctrl

Overview:
Parametrised interpolation/timing controller for the symbol-recovery chain. It sits between the PI loop filter output and the RX polyphase filter / TED enable logic. It integrates the loop-filter correction into a fractional phase mu and emits the polyphase phase index. It also generates the symbol strobe with sample skip/stuff on mu wrap, and adds freeze, preload, overflow flagging and lock detection.

Parameters:
NB_ERR, 27, width of signed loop-filter correction; its LSB weight equals the mu LSB weight
NB_MU, 22, width of unsigned mu accumulator, representing [0,1)
NB_PH, 4, phase index width (2^NB_PH polyphase branches); NB_PH <= NB_MU
SPS, 2, input samples per symbol; SPS >= 2
MAX_STEP, 2^(NB_MU-2), magnitude clamp applied to the correction before integration
LOCK_THR, 2^12, |correction| strictly below this counts as "good"
LOCK_CNT, 8, consecutive good corrections needed to assert lock
UNLOCK_CNT, 4, consecutive bad corrections needed to drop lock

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_sample_en  in  1  one-cycle pulse per input sample
i_err_valid  in  1  one-cycle pulse, i_err valid
i_err  in  NB_ERR  signed correction from loop filter
i_freeze  in  1  hold mu; lock detection continues
i_load  in  1  load mu from i_mu_init
i_mu_init  in  NB_MU  preload value
o_strobe  out  1  symbol strobe pulse
o_phase_idx  out  NB_PH  mu[NB_MU-1 -: NB_PH]
o_mu  out  NB_MU  current mu
o_skip  out  1  pulse, mu wrapped upward
o_stuff  out  1  pulse, mu wrapped downward
o_ovf  out  1  sticky, slip request lost
o_lock  out  1  timing lock indicator

Behaviour:
- Reset (rst_n low, async): all outputs, mu, sample counter cnt, pending flags and lock counters go to 0 immediately.
- Step = i_err clamped to [-MAX_STEP, +MAX_STEP].
- Integration happens on i_err_valid when neither i_load nor i_freeze is asserted.
  - sum = {2'b0,mu} + sign-extended step, computed in NB_MU+2 bits.
  - sum >= 2^NB_MU: up-wrap. sum < 0: down-wrap.
  - mu <= sum mod 2^NB_MU.
- Priority: i_load > i_freeze > integration.
  - i_load: mu <= i_mu_init; clears pending flags, o_ovf, lock and lock counters; no skip/stuff pulse.
- Update latency: o_mu, o_phase_idx, o_skip and o_stuff are registered and take effect 1 cycle after the i_err_valid cycle. o_skip and o_stuff are never high together.
- Pending flags:
  - Up-wrap sets skip_pend; down-wrap sets stuff_pend.
  - Wrap while the same-type flag is already pending: set o_ovf; the flag stays single.
  - Wrap of the opposite type while a flag is pending: clear both flags; no ovf.
  - A wrap in the same cycle as i_sample_en takes effect at the next i_sample_en.
- Strobe generator, evaluated on i_sample_en; o_strobe is asserted the following cycle for 1 cycle:
  - skip_pend: strobe, cnt <= 0, clear skip_pend.
  - else cnt == SPS-1 and stuff_pend: no strobe, cnt holds, clear stuff_pend.
  - else cnt == SPS-1: strobe, cnt <= 0.
  - else cnt <= cnt+1.
- Lock detection, on every i_err_valid (including while frozen), using the unclamped |i_err|:
  - |i_err| < LOCK_THR: good_cnt increments, bad_cnt <= 0.
  - Otherwise: bad_cnt increments, good_cnt <= 0.
  - Both counters saturate.
  - o_lock sets on the valid that brings good_cnt to LOCK_CNT.
  - o_lock clears on the valid that brings bad_cnt to UNLOCK_CNT.
  - o_lock is registered, 1-cycle latency.
- Boundaries:
  - mu = 2^NB_MU-1 with step +1 gives mu = 0 and o_skip.
  - mu = 0 with step -1 gives mu = 2^NB_MU-1 and o_stuff.
  - Step = 0 gives no event.
  - i_err = most-negative value clamps to -MAX_STEP.

Decomposition:
- Shared package/header holds:
  - defaults for NB_MU, NB_PH and SPS, common with the polyphase filters;
  - the lock-count width macro;
  - localparams MU_ONE = 2^NB_MU and the clamp limits.
- One sub-module: timing_lock_detector, containing the good/bad counters and o_lock, parametrised by NB_ERR, LOCK_THR, LOCK_CNT and UNLOCK_CNT.

Test Plan:
1. Reset, then i_sample_en every 32 clk with no i_err_valid → o_strobe on every 2nd sample, 1 cycle after the pulse; o_phase_idx = 0.
2. Wrap up: i_load with 0x3C0000, then i_err = +0x080000 → o_mu = 0x040000, o_phase_idx = 1, o_skip pulse. The next i_sample_en strobes regardless of cnt.
3. Wrap down: mu = 0, i_err = -1 → o_mu = 0x3FFFFF, o_phase_idx = 15, o_stuff pulse. The next due strobe is withheld one sample, so the strobe gap is 3 samples.
4. Clamp, freeze and load priority:
   - i_err = 0x1000000, mu = 0 → o_mu = 0x100000.
   - i_freeze with i_err = 5 → mu unchanged.
   - i_load and i_freeze together → mu = i_mu_init.
5. Overflow: two up-wraps before any i_sample_en → o_ovf = 1 (sticky) with a single skip. An up-wrap followed by a down-wrap → no slip, o_ovf = 0. An i_load clears o_ovf.
6. Lock and async reset:
   - Eight i_err = 0x10 → o_lock rises 1 cycle after the 8th.
   - Four i_err = 0x2000 → o_lock falls after the 4th.
   - rst_n low between edges mid-run → all outputs 0 before the next edge.
